// File: rtl/rename_map_unit.sv
// rtl/rename_map_unit.sv - register rename unit: speculative map (FRAT), retirement map (RRAT), bit-vector free list
// One rename per cycle; ROB commits update the RRAT and free tags; flush restores the FRAT from the RRAT.
module rename_map_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(ARCH_REGS)-1:0] in_srcA,
  input  logic [$clog2(ARCH_REGS)-1:0] in_srcB,
  input  logic [$clog2(ARCH_REGS)-1:0] in_dst,
  input  logic                         in_wr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(PHYS_REGS)-1:0] out_psrcA,
  output logic [$clog2(PHYS_REGS)-1:0] out_psrcB,
  output logic [$clog2(PHYS_REGS)-1:0] out_pdst,
  output logic [$clog2(PHYS_REGS)-1:0] out_old_pdst,
  input  logic                         cm_valid,
  input  logic [$clog2(ARCH_REGS)-1:0] cm_arch,
  input  logic [$clog2(PHYS_REGS)-1:0] cm_pdst,
  input  logic [$clog2(PHYS_REGS)-1:0] cm_old_pdst,
  input  logic                         flush,
  output logic [$clog2(PHYS_REGS):0]   free_count
);
  localparam int PTAG_W = $clog2(PHYS_REGS);
  localparam int CNT_W  = PTAG_W + 1;

  logic [PTAG_W-1:0]    r_frat [ARCH_REGS];
  logic [PTAG_W-1:0]    r_rrat [ARCH_REGS];
  logic [PHYS_REGS-1:0] r_free_vec;
  logic [CNT_W-1:0]     r_free_count;
  logic                 r_out_valid;
  logic [PTAG_W-1:0]    r_out_psrcA;
  logic [PTAG_W-1:0]    r_out_psrcB;
  logic [PTAG_W-1:0]    r_out_pdst;
  logic [PTAG_W-1:0]    r_out_old_pdst;

  logic                 w_needs_alloc;
  logic                 w_accept;
  logic                 w_alloc;
  logic                 w_commit;
  logic [PTAG_W-1:0]    w_alloc_tag;
  logic [PTAG_W-1:0]    w_rrat_next [ARCH_REGS];
  logic [PHYS_REGS-1:0] w_free_next;
  logic [CNT_W-1:0]     w_free_count_next;

  assign w_needs_alloc = in_wr && (in_dst != '0);
  assign in_ready      = !flush && (!r_out_valid || out_ready) &&
                         (!w_needs_alloc || (r_free_count != '0));
  assign w_accept      = in_valid && in_ready;
  assign w_alloc       = w_accept && w_needs_alloc;
  assign w_commit      = cm_valid && (cm_arch != '0) && (cm_old_pdst != '0);

  // Lowest-index free tag; only consulted when free_count is non-zero.
  always_comb begin
    w_alloc_tag = '0;
    for (int p = PHYS_REGS - 1; p >= 0; p--) begin
      if (r_free_vec[p]) w_alloc_tag = PTAG_W'(p);
    end
  end

  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) w_rrat_next[i] = r_rrat[i];
    if (w_commit) w_rrat_next[cm_arch] = cm_pdst;
  end

  // A flush rebuilds the free list as everything the post-commit RRAT does not map.
  always_comb begin
    w_free_next = r_free_vec;
    if (flush) begin
      w_free_next = '1;
      for (int i = 0; i < ARCH_REGS; i++) w_free_next[w_rrat_next[i]] = 1'b0;
      w_free_next[0] = 1'b0;
    end else begin
      if (w_alloc)  w_free_next[w_alloc_tag] = 1'b0;
      if (w_commit) w_free_next[cm_old_pdst] = 1'b1;
    end
  end

  always_comb begin
    w_free_count_next = '0;
    for (int p = 0; p < PHYS_REGS; p++) begin
      w_free_count_next = w_free_count_next + CNT_W'(w_free_next[p]);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_frat[i] <= PTAG_W'(i);
        r_rrat[i] <= PTAG_W'(i);
      end
      for (int p = 0; p < PHYS_REGS; p++) r_free_vec[p] <= (p >= ARCH_REGS);
      r_free_count <= CNT_W'(PHYS_REGS - ARCH_REGS);
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) r_rrat[i] <= w_rrat_next[i];
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++) r_frat[i] <= w_rrat_next[i];
      end else if (w_alloc) begin
        r_frat[in_dst] <= w_alloc_tag;
      end
      r_free_vec   <= w_free_next;
      r_free_count <= w_free_count_next;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_out_valid    <= 1'b0;
      r_out_psrcA    <= '0;
      r_out_psrcB    <= '0;
      r_out_pdst     <= '0;
      r_out_old_pdst <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_psrcA    <= r_frat[in_srcA];
      r_out_psrcB    <= r_frat[in_srcB];
      r_out_pdst     <= w_alloc ? w_alloc_tag : '0;
      r_out_old_pdst <= w_alloc ? r_frat[in_dst] : '0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_psrcA    = r_out_psrcA;
  assign out_psrcB    = r_out_psrcB;
  assign out_pdst     = r_out_pdst;
  assign out_old_pdst = r_out_old_pdst;
  assign free_count   = r_free_count;

endmodule

// File: tb/tb_rename_map_unit.sv
// tb/tb_rename_map_unit.sv - directed bench for rename_map_unit with a per-cycle reference model
module tb_rename_map_unit;
  localparam int AR = 32;
  localparam int PR = 64;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       in_valid, in_ready, in_wr, out_valid, out_ready;
  logic [4:0] in_srcA, in_srcB, in_dst, cm_arch;
  logic [5:0] out_psrcA, out_psrcB, out_pdst, out_old_pdst, cm_pdst, cm_old_pdst;
  logic       cm_valid, flush;
  logic [6:0] free_count;

  rename_map_unit #(.ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_srcA(in_srcA), .in_srcB(in_srcB), .in_dst(in_dst), .in_wr(in_wr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psrcA(out_psrcA), .out_psrcB(out_psrcB), .out_pdst(out_pdst), .out_old_pdst(out_old_pdst),
    .cm_valid(cm_valid), .cm_arch(cm_arch), .cm_pdst(cm_pdst), .cm_old_pdst(cm_old_pdst),
    .flush(flush), .free_count(free_count)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Reference model: plain arrays, a free-flag per tag, and a count of uncommitted renames.
  int m_frat [AR];
  int m_rrat [AR];
  bit m_free [PR];
  int m_inflight;
  bit m_out_valid;
  int m_psrcA, m_psrcB, m_pdst, m_old;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_free_cnt();
    int c = 0;
    for (int p = 0; p < PR; p++) c += int'(m_free[p]);
    return c;
  endfunction

  function automatic int m_lowest_free();
    for (int p = 0; p < PR; p++) if (m_free[p]) return p;
    return -1;
  endfunction

  function automatic bit m_ready();
    bit needs = in_wr && (in_dst != 0);
    return !flush && (!m_out_valid || out_ready) && (!needs || m_free_cnt() != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < AR; i++) begin m_frat[i] = i; m_rrat[i] = i; end
    for (int p = 0; p < PR; p++) m_free[p] = (p >= AR);
    m_inflight = 0;
    m_out_valid = 1'b0;
    m_psrcA = 0; m_psrcB = 0; m_pdst = 0; m_old = 0;
  endtask

  task automatic model_step();
    bit needs = in_wr && (in_dst != 0);
    bit acc   = in_valid && m_ready();
    int p;
    if (flush) begin
      m_out_valid = 1'b0;
    end else if (acc) begin
      m_out_valid = 1'b1;
      m_psrcA = m_frat[in_srcA];
      m_psrcB = m_frat[in_srcB];
      if (needs) begin
        p = m_lowest_free();
        m_free[p] = 1'b0;
        m_pdst = p;
        m_old = m_frat[in_dst];
        m_frat[in_dst] = p;
        m_inflight++;
      end else begin
        m_pdst = 0;
        m_old = 0;
      end
    end else if (out_ready) begin
      m_out_valid = 1'b0;
    end
    if (cm_valid && cm_arch != 0 && cm_old_pdst != 0) begin
      m_rrat[cm_arch] = cm_pdst;
      m_free[cm_old_pdst] = 1'b1;
      m_inflight--;
    end
    if (flush) begin
      for (int i = 0; i < AR; i++) m_frat[i] = m_rrat[i];
      for (int q = 0; q < PR; q++) m_free[q] = 1'b1;
      for (int i = 0; i < AR; i++) m_free[m_rrat[i]] = 1'b0;
      m_free[0] = 1'b0;
      m_inflight = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (check_en) begin
        chk("out_valid", out_valid, m_out_valid);
        if (m_out_valid) begin
          chk("out_psrcA", out_psrcA, m_psrcA);
          chk("out_psrcB", out_psrcB, m_psrcB);
          chk("out_pdst", out_pdst, m_pdst);
          chk("out_old_pdst", out_old_pdst, m_old);
        end
        chk("in_ready", in_ready, m_ready());
        chk("free_count", free_count, m_free_cnt());
        if (!RESET) chk("invariant", int'(free_count) + AR + m_inflight, PR);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_wr = 0; in_srcA = 0; in_srcB = 0; in_dst = 0;
    out_ready = 1; cm_valid = 0; cm_arch = 0; cm_pdst = 0; cm_old_pdst = 0; flush = 0;
  endtask

  task automatic ren(input int a, input int b, input int d, input bit w);
    in_valid = 1; in_srcA = 5'(a); in_srcB = 5'(b); in_dst = 5'(d); in_wr = w;
    tick();
  endtask

  task automatic do_reset();
    RESET = 1; idle();
    tick(); tick();
    RESET = 0;
    check_en = 1'b1;
  endtask

  task automatic chk_out(input string tag, input int a, input int b, input int d, input int o);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".psrcA"}, out_psrcA, a);
    chk({tag, ".psrcB"}, out_psrcB, b);
    chk({tag, ".pdst"}, out_pdst, d);
    chk({tag, ".old_pdst"}, out_old_pdst, o);
  endtask

  initial begin
    idle();
    do_reset();
    chk("reset.out_valid", out_valid, 0);
    chk("reset.free_count", free_count, 32);
    chk("reset.in_ready", in_ready, 1);

    ren(2, 3, 1, 1);
    chk_out("first", 2, 3, 32, 1);
    chk("first.free_count", free_count, 31);
    idle(); tick();

    do_reset();
    ren(5, 0, 5, 1);
    chk_out("dep0", 5, 0, 32, 5);
    ren(5, 5, 6, 1);
    chk_out("dep1", 32, 32, 33, 6);
    idle(); tick();

    do_reset();
    for (int i = 0; i < 32; i++) ren(0, 0, (i % 31) + 1, 1);
    chk("empty.free_count", free_count, 0);
    in_valid = 1; in_srcA = 1; in_srcB = 2; in_dst = 3; in_wr = 1;
    #1 chk("empty.in_ready_wr", in_ready, 0);
    in_wr = 0;
    #1 chk("empty.in_ready_nowr", in_ready, 1);
    tick();
    chk_out("nowr", 63, 33, 0, 0);
    cm_valid = 1; cm_arch = 7; cm_pdst = 38; cm_old_pdst = 7;
    in_valid = 1; in_srcA = 0; in_srcB = 0; in_dst = 9; in_wr = 1;
    #1 chk("commit.same_cycle_ready", in_ready, 0);
    tick();
    cm_valid = 0;
    #1 chk("commit.free_count", free_count, 1);
    chk("commit.next_ready", in_ready, 1);
    tick();
    chk_out("reuse", 0, 0, 7, 40);
    chk("reuse.free_count", free_count, 0);
    idle(); tick();

    do_reset();
    out_ready = 0;
    ren(1, 2, 3, 1);
    in_srcA = 4; in_srcB = 5; in_dst = 6;
    for (int k = 0; k < 3; k++) begin
      chk("hold.in_ready", in_ready, 0);
      chk_out("hold", 1, 2, 32, 3);
      tick();
    end
    out_ready = 1;
    #1 chk("release.in_ready", in_ready, 1);
    tick();
    chk_out("release", 4, 5, 33, 6);
    idle(); tick();
    chk("drain.out_valid", out_valid, 0);

    do_reset();
    ren(0, 0, 1, 1);
    ren(0, 0, 2, 1);
    cm_valid = 1; cm_arch = 1; cm_pdst = 32; cm_old_pdst = 1; flush = 1;
    in_valid = 1; in_srcA = 3; in_srcB = 3; in_dst = 3; in_wr = 1;
    #1 chk("flush.in_ready", in_ready, 0);
    tick();
    idle();
    #1 chk("flush.out_valid", out_valid, 0);
    chk("flush.free_count", free_count, 32);
    ren(1, 2, 4, 1);
    chk_out("post_flush", 32, 2, 1, 4);
    idle(); tick();

    do_reset();
    out_ready = 0;
    ren(1, 2, 3, 1);
    in_valid = 0;
    chk("midrst.pre_valid", out_valid, 1);
    #2 RESET = 1;
    #1 chk("midrst.out_valid", out_valid, 0);
    chk("midrst.free_count", free_count, 32);
    tick();
    RESET = 0;
    idle();
    ren(3, 3, 3, 1);
    chk_out("midrst.identity", 3, 3, 32, 3);
    idle();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
